// File: rtl/init_seq_pkg.sv
// Shared types and default sizing for the multi-channel init sequencer.
package init_seq_pkg;

    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_REQ    = 2'd2,
        ST_DONE   = 2'd3
    } init_state_e;

endpackage

// File: rtl/init_seq_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next channel to initialise.
module init_seq_prio_enc
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_vec,
    output logic [IDX_W-1:0]  o_idx_c,
    output logic              o_valid_c
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx_c   = IDX_W'(i);
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/init_seq_mc.sv
// Multi-channel init sequencer: requests each masked channel in index order,
// waits for ack or timeout, and reports ok/err masks with a done pulse.
module init_seq_mc
    import init_seq_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_ack,
    output logic [NUM_CH-1:0] ch_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [NUM_CH-1:0] err_mask
);

    localparam int unsigned CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    init_state_e       r_state,   w_state_nxt;
    logic [NUM_CH-1:0] r_pending, w_pending_nxt;
    logic [NUM_CH-1:0] r_ok,      w_ok_nxt;
    logic [NUM_CH-1:0] r_err,     w_err_nxt;
    logic [NUM_CH-1:0] r_ch_req,  w_ch_req_nxt;
    logic [CUR_W-1:0]  r_cur,     w_cur_nxt;
    logic [TMR_W-1:0]  r_timer,   w_timer_nxt;
    logic              r_busy,    w_busy_nxt;
    logic              r_done,    w_done_nxt;

    logic [CUR_W-1:0]  w_sel_idx;
    logic              w_sel_vld;
    logic [NUM_CH-1:0] w_cur_bit;
    logic [NUM_CH-1:0] w_sel_bit;
    logic              w_ack_cur;

    init_seq_prio_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CUR_W)
    ) u_prio_enc (
        .i_vec     (r_pending),
        .o_idx_c   (w_sel_idx),
        .o_valid_c (w_sel_vld)
    );

    assign w_cur_bit = NUM_CH'(1) << r_cur;
    assign w_sel_bit = NUM_CH'(1) << w_sel_idx;
    assign w_ack_cur = |(ch_ack & w_cur_bit);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ok      <= '0;
            r_err     <= '0;
            r_ch_req  <= '0;
            r_cur     <= '0;
            r_timer   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_ok      <= w_ok_nxt;
            r_err     <= w_err_nxt;
            r_ch_req  <= w_ch_req_nxt;
            r_cur     <= w_cur_nxt;
            r_timer   <= w_timer_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; ch_req is registered off the next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_ok_nxt      = r_ok;
        w_err_nxt     = r_err;
        w_ch_req_nxt  = '0;
        w_cur_nxt     = r_cur;
        w_timer_nxt   = r_timer;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pending_nxt = ch_mask;
                    w_ok_nxt      = '0;
                    w_err_nxt     = '0;
                    w_timer_nxt   = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (abort) begin
                    w_err_nxt     = r_err | r_pending;
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_DONE;
                end else if (!w_sel_vld) begin
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_cur_nxt     = w_sel_idx;
                    w_timer_nxt   = '0;
                    w_ch_req_nxt  = w_sel_bit;
                    w_state_nxt   = ST_REQ;
                end
            end

            ST_REQ: begin
                if (abort) begin
                    w_err_nxt     = r_err | r_pending;
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_DONE;
                end else if (w_ack_cur) begin
                    w_ok_nxt      = r_ok | w_cur_bit;
                    w_pending_nxt = r_pending & ~w_cur_bit;
                    w_state_nxt   = ST_SELECT;
                end else if (r_timer == TMR_LAST) begin
                    w_err_nxt     = r_err | w_cur_bit;
                    w_pending_nxt = r_pending & ~w_cur_bit;
                    w_state_nxt   = ST_SELECT;
                end else begin
                    w_timer_nxt   = r_timer + TMR_W'(1);
                    w_ch_req_nxt  = w_cur_bit;
                end
            end

            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ch_req   = r_ch_req;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = DATA_W'(r_ok);
    assign err_mask = r_err;

endmodule

// File: tb/tb_init_seq_mc.sv
// Randomized self-checking bench for init_seq_mc against a per-channel timeline model.
module tb_init_seq_mc;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 64;
    localparam int          MAXC = 512;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [NCH-1:0] ch_mask;
    logic           abort;
    logic [NCH-1:0] ch_ack;
    logic [NCH-1:0] ch_req;
    logic           busy;
    logic           done;
    logic [DW-1:0]  result;
    logic [NCH-1:0] err_mask;

    int n_chk  = 0;
    int n_fail = 0;

    // Per-channel plan: ack or not, and on which REQ cycle (0 = first) the ack comes.
    bit acked [NCH];
    int dly   [NCH];
    bit noise_en;

    logic [NCH-1:0] exp_req [MAXC];
    logic [NCH-1:0] ack_drv [MAXC];

    init_seq_mc #(
        .NUM_CH  (NCH),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ch_mask  (ch_mask),
        .abort    (abort),
        .ch_ack   (ch_ack),
        .ch_req   (ch_req),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err_mask (err_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NCH-1:0] v);
        for (int i = 0; i < int'(NCH); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Build the expected timeline from the plan, then drive and check cycle by cycle.
    // Cycle 0 is the cycle right after the edge that accepts start.
    task automatic run_seq(input logic [NCH-1:0] mask, input int abort_at);
        logic [NCH-1:0] pend, ok, err, bitk, noise;
        int s, fin, len, k, d, last;
        bit hit;

        for (int c = 0; c < MAXC; c++) begin
            exp_req[c] = '0;
            ack_drv[c] = '0;
        end
        pend = mask; ok = '0; err = '0; s = 0; fin = -1;
        while (fin < 0) begin
            if (abort_at == s) begin
                err |= pend;
                fin = s + 1;
            end else if (pend == '0) begin
                fin = s + 1;
            end else begin
                k    = lowest(pend);
                bitk = NCH'(1) << k;
                len  = acked[k] ? dly[k] + 1 : int'(TO);
                hit  = (abort_at > s) && (abort_at <= s + len);
                last = hit ? abort_at : s + len;
                for (int c = s + 1; c <= last; c++) exp_req[c] = bitk;
                if (hit) begin
                    err |= pend;
                    fin = abort_at + 1;
                end else begin
                    if (acked[k]) begin
                        ack_drv[s + len] = bitk;
                        ok |= bitk;
                    end else begin
                        err |= bitk;
                    end
                    pend &= ~bitk;
                    s += len + 1;
                end
            end
        end
        d = fin + 1;

        start   = 1'b1;
        ch_mask = mask;
        abort   = 1'b0;
        ch_ack  = noise_en ? NCH'($urandom) : '0;
        next_cycle();
        start   = 1'b0;
        ch_mask = NCH'($urandom);

        for (int c = 0; c <= d; c++) begin
            chk("ch_req", 64'(ch_req), 64'(exp_req[c]));
            chk("busy",   64'(busy),   64'(c < d));
            chk("done",   64'(done),   64'(c == d));
            if (c < d) begin
                noise  = noise_en ? (NCH'($urandom) & ~exp_req[c]) : '0;
                ch_ack = ack_drv[c] | noise;
                abort  = (c == abort_at);
                start  = noise_en && ($urandom_range(0, 3) == 0);
                next_cycle();
            end else begin
                ch_ack = '0;
                abort  = 1'b0;
                start  = 1'b0;
            end
        end
        chk("result",   64'(result),   64'(DW'(ok)));
        chk("err_mask", 64'(err_mask), 64'(err));
        chk("disjoint", 64'(result[NCH-1:0] & err_mask), 64'(0));
        chk("cover",    64'(result[NCH-1:0] | err_mask), 64'(mask));

        next_cycle();
        chk("idle_req",    64'(ch_req),   64'(0));
        chk("idle_done",   64'(done),     64'(0));
        chk("idle_busy",   64'(busy),     64'(0));
        chk("result_hold", 64'(result),   64'(DW'(ok)));
        chk("err_hold",    64'(err_mask), 64'(err));
    endtask

    task automatic set_plan(input bit ack_all, input int d);
        for (int i = 0; i < int'(NCH); i++) begin
            acked[i] = ack_all;
            dly[i]   = d;
        end
    endtask

    // Reset asserted in the middle of a REQ: everything drops without a done pulse.
    task automatic reset_mid_req();
        start   = 1'b1;
        ch_mask = 4'b0100;
        ch_ack  = '0;
        abort   = 1'b0;
        next_cycle();
        start = 1'b0;
        repeat (4) next_cycle();
        chk("pre_rst_req",  64'(ch_req), 64'(4'b0100));
        chk("pre_rst_busy", 64'(busy),   64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",    64'(ch_req),   64'(0));
        chk("rst_busy",   64'(busy),     64'(0));
        chk("rst_done",   64'(done),     64'(0));
        chk("rst_result", 64'(result),   64'(0));
        chk("rst_err",    64'(err_mask), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        chk("post_rst_done", 64'(done),   64'(0));
        chk("post_rst_req",  64'(ch_req), 64'(0));
    endtask

    initial begin
        int ab;
        logic [NCH-1:0] m;

        rst_n    = 1'b0;
        start    = 1'b0;
        ch_mask  = '0;
        abort    = 1'b0;
        ch_ack   = '0;
        noise_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req",    64'(ch_req),   64'(0));
        chk("reset_busy",   64'(busy),     64'(0));
        chk("reset_done",   64'(done),     64'(0));
        chk("reset_result", 64'(result),   64'(0));
        chk("reset_err",    64'(err_mask), 64'(0));
        rst_n = 1'b1;
        next_cycle();

        // Empty mask: done two edges after start.
        set_plan(1'b1, 0);
        run_seq(4'b0000, -1);

        // Two channels, each acked one cycle into its REQ.
        set_plan(1'b1, 1);
        run_seq(4'b1010, -1);

        // Single channel never acked: full timeout.
        set_plan(1'b0, 0);
        run_seq(4'b0001, -1);

        // Ack on the very last allowed REQ cycle still counts as ok.
        set_plan(1'b1, int'(TO) - 1);
        run_seq(4'b0100, -1);

        // Abort while channel 1 is being requested.
        set_plan(1'b1, 5);
        acked[0] = 1'b1; dly[0] = 0;
        run_seq(4'b1111, 4);

        // Abort in the very first SELECT cycle.
        set_plan(1'b1, 0);
        run_seq(4'b0110, 0);

        // Stray starts and acks on idle channels while busy, then reset mid-REQ.
        noise_en = 1'b1;
        set_plan(1'b1, 2);
        run_seq(4'b1001, -1);
        reset_mid_req();
        set_plan(1'b1, 0);
        run_seq(4'b0011, -1);

        for (int n = 0; n < 40; n++) begin
            m = NCH'($urandom);
            for (int i = 0; i < int'(NCH); i++) begin
                acked[i] = ($urandom_range(0, 4) != 0);
                dly[i]   = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 5));
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            noise_en = ($urandom_range(0, 1) == 1);
            run_seq(m, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/init_seq_mc.md
INIT_SEQ_MC -- requirements
Module: init_seq_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of init channels (1..16).
REQ-002 Parameter DATA_W, default 32, result width (>= NUM_CH).
REQ-003 Parameter TIMEOUT, default 64, max cycles a channel request waits for ack (>= 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin sequence; sampled only in IDLE.
REQ-007 ch_mask  input  NUM_CH  channels to initialise; latched when start is accepted.
REQ-008 abort  input  1  terminate sequence; sampled in SELECT and REQ.
REQ-009 ch_ack  input  NUM_CH  per-channel init-complete acknowledge.
REQ-010 ch_req  output  NUM_CH  registered, one-hot or zero request to the active channel.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 result  output  DATA_W  ok-channel mask, zero-extended.
REQ-014 err_mask  output  NUM_CH  channels that timed out or were aborted.

Function
REQ-015 FSM states SHALL be IDLE, SELECT, REQ and DONE; all outputs registered.
REQ-016 IDLE: start=1 SHALL latch pending=ch_mask, clear result/err_mask/timer, go to SELECT; busy=1 next cycle.
REQ-017 start in any state other than IDLE SHALL be ignored.
REQ-018 SELECT: abort=1 -> err_mask |= pending, pending=0, go to DONE (priority over everything).
REQ-019 SELECT: pending==0 -> DONE; else cur = index of lowest set pending bit, timer=0, go to REQ.
REQ-020 REQ: ch_req SHALL be one-hot on cur for every REQ cycle and zero in all other states.
REQ-021 REQ priority order: abort (as REQ-018) > ch_ack[cur] > timeout.
REQ-022 REQ with ch_ack[cur]=1: set result bit cur, clear pending bit cur, go to SELECT.
REQ-023 REQ with timer==TIMEOUT-1 and no ack: set err_mask bit cur, clear pending bit cur, go to SELECT.
REQ-024 Otherwise, in REQ: timer increments by 1; timer width is clog2(TIMEOUT), never wraps.
REQ-025 ch_ack bits other than cur SHALL be ignored.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then go to IDLE.
REQ-027 result and err_mask SHALL hold until the next accepted start; result[DATA_W-1:NUM_CH]=0 always.
REQ-028 Latency (edge 0 = start accepted): mask 0 -> done high after edge 2; one channel acked in its first REQ cycle -> done high after edge 4.
REQ-029 result & err_mask SHALL always be 0, and (result|err_mask) SHALL equal the latched mask at done.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, ch_req=0, busy=0, done=0, result=0, err_mask=0, pending=0, timer=0.
REQ-031 Reset mid-sequence SHALL drop ch_req without a done pulse; the first start after release runs normally.

Structure
REQ-032 Package init_seq_pkg SHALL hold the state enum and the default NUM_CH/DATA_W/TIMEOUT constants.
REQ-033 Lowest-set-bit selection SHALL be a combinational sub-module init_seq_prio_enc (NUM_CH in, index + valid out).

Verification
REQ-034 NUM_CH=4, mask=4'b0000, start -> done after edge 2, result=0, err_mask=0, ch_req never set.
REQ-035 mask=4'b1010, ack one cycle into each REQ -> ch_req 4'b0010 then 4'b1000, result=32'h0000000A, err_mask=0.
REQ-036 mask=4'b0001, ch_ack held 0, TIMEOUT=64 -> ch_req[0] high exactly 64 cycles, err_mask=4'b0001, result=0.
REQ-037 mask=4'b1111, ch0 acked, abort during ch1 REQ -> result=4'h1, err_mask=4'b1110, done next cycle after SELECT-free exit.
REQ-038 start pulsed while busy and ch_ack on a non-active channel -> no restart, no effect on result; then rst_n low mid-REQ -> all outputs 0 immediately.
